// File: rtl/mips_prog_loader.sv
// Boot loader for the two-phase MIPS core: streams a program into instruction memory, then runs and supervises the core.
// Optional feature macro CHECKSUM_EN: require and verify an XOR trailer word after the program.
module mips_prog_loader #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              load_req,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_rst,
  input  logic              core_halted,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [23:0]       cycle_cnt
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned CNT_W = 24;
  localparam logic [LEN_W-1:0] MAX_LEN     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_SUM  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_RUN, S_DONE, S_ERROR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] word_cnt;
  logic [ADDR_W-1:0] last_idx;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              accept;
`ifdef CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  // Memory write port follows the stream handshake in the same cycle.
  assign accept    = in_valid & in_ready;
  assign mem_we    = accept & (state == S_LOAD);
  assign mem_addr  = word_cnt;
  assign mem_wdata = mem_we ? in_data : '0;
  assign cnt_nxt   = (cycle_cnt == CNT_MAX) ? cycle_cnt : cycle_cnt + CNT_W'(1);

  always_ff @(posedge clk1) begin
    if (rst) begin
      state     <= S_IDLE;
      word_cnt  <= '0;
      last_idx  <= '0;
      in_ready  <= 1'b0;
      core_rst  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      cycle_cnt <= '0;
`ifdef CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (load_req) begin
            core_rst <= 1'b1;
            done     <= 1'b0;
            if (load_len == '0 || load_len > MAX_LEN) begin
              state    <= S_ERROR;
              err      <= 1'b1;
              err_code <= ERR_LEN;
            end else begin
              state     <= S_LOAD;
              word_cnt  <= '0;
              last_idx  <= ADDR_W'(load_len - LEN_W'(1));
              cycle_cnt <= '0;
              in_ready  <= 1'b1;
              busy      <= 1'b1;
              err       <= 1'b0;
              err_code  <= ERR_NONE;
`ifdef CHECKSUM_EN
              csum      <= '0;
`endif
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            word_cnt <= word_cnt + ADDR_W'(1);
`ifdef CHECKSUM_EN
            csum <= csum ^ in_data;
            if (word_cnt == last_idx) begin
              state <= S_CHECK;
            end
`else
            if (word_cnt == last_idx) begin
              state    <= S_RUN;
              in_ready <= 1'b0;
              core_rst <= 1'b0;
            end
`endif
          end
        end
`ifdef CHECKSUM_EN
        // Trailer word must equal the XOR of every program word.
        S_CHECK: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state    <= S_RUN;
              core_rst <= 1'b0;
            end else begin
              state    <= S_ERROR;
              busy     <= 1'b0;
              err      <= 1'b1;
              err_code <= ERR_SUM;
            end
          end
        end
`endif
        // Halt takes priority over a timeout landing on the same cycle.
        S_RUN: begin
          if (core_halted) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cycle_cnt <= cnt_nxt;
            if (cnt_nxt >= TIMEOUT_CNT) begin
              state    <= S_ERROR;
              busy     <= 1'b0;
              err      <= 1'b1;
              err_code <= ERR_TMO;
              core_rst <= 1'b1;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          core_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Self-checking bench for mips_prog_loader: phase-level model checked every cycle plus directed literal checks.
module tb_mips_prog_loader;

  localparam int MAIN_TMO = 4096;
`ifdef CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk1 = 1'b0;
  logic        rst = 1'b1;
  logic        load_req = 1'b0;
  logic [10:0] load_len = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        core_halted = 1'b0;
  logic        halted_t = 1'b0;

  logic        in_ready, mem_we, core_rst, busy, done, err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  err_code;
  logic [23:0] cycle_cnt;

  logic        in_ready_t, mem_we_t, core_rst_t, busy_t, done_t, err_t;
  logic [9:0]  mem_addr_t;
  logic [31:0] mem_wdata_t;
  logic [1:0]  err_code_t;
  logic [23:0] cycle_cnt_t;

  always #5 clk1 = ~clk1;

  mips_prog_loader u_dut (
    .clk1(clk1), .rst(rst), .load_req(load_req), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst(core_rst), .core_halted(core_halted), .busy(busy),
    .done(done), .err(err), .err_code(err_code), .cycle_cnt(cycle_cnt)
  );

  mips_prog_loader #(.TIMEOUT(16)) u_to (
    .clk1(clk1), .rst(rst), .load_req(load_req), .load_len(load_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_t),
    .mem_we(mem_we_t), .mem_addr(mem_addr_t), .mem_wdata(mem_wdata_t),
    .core_rst(core_rst_t), .core_halted(halted_t), .busy(busy_t),
    .done(done_t), .err(err_t), .err_code(err_code_t), .cycle_cnt(cycle_cnt_t)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model of the main instance: loader phase, words taken, run cycles, error code.
  typedef enum {P_IDLE, P_LOAD, P_CHK, P_RUN, P_DONE, P_ERR} ph_t;
  ph_t         ph = P_IDLE;
  int          m_len = 0;
  int          m_nacc = 0;
  int          m_cnt = 0;
  logic [1:0]  m_code = 2'd0;
  logic [31:0] m_xs = '0;

  logic [31:0] prog [0:15];
  logic [31:0] mem_img [0:1023];
  int          wcount = 0;

  always @(posedge clk1) begin
    if (rst) begin
      ph <= P_IDLE; m_nacc <= 0; m_cnt <= 0; m_code <= 2'd0; m_xs <= '0;
    end else begin
      case (ph)
        P_IDLE, P_DONE, P_ERR:
          if (load_req) begin
            if (load_len == 0 || int'(load_len) > 1024) begin
              ph <= P_ERR; m_code <= 2'd1;
            end else begin
              ph <= P_LOAD; m_len <= int'(load_len); m_nacc <= 0;
              m_cnt <= 0; m_code <= 2'd0; m_xs <= '0;
            end
          end
        P_LOAD:
          if (in_valid) begin
            m_nacc <= m_nacc + 1;
            m_xs <= m_xs ^ in_data;
            if (m_nacc + 1 == m_len) ph <= CSUM ? P_CHK : P_RUN;
          end
        P_CHK:
          if (in_valid) begin
            if (in_data == m_xs) ph <= P_RUN;
            else begin ph <= P_ERR; m_code <= 2'd2; end
          end
        P_RUN:
          if (core_halted) ph <= P_DONE;
          else begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 >= MAIN_TMO) begin ph <= P_ERR; m_code <= 2'd3; end
          end
        default: ph <= P_IDLE;
      endcase
    end
  end

  // Per-cycle compare of the main instance against the model, plus write capture.
  initial begin
    @(posedge clk1);
    forever begin
      @(negedge clk1);
      chk("cyc in_ready", 32'(in_ready), 32'(ph == P_LOAD || ph == P_CHK));
      chk("cyc busy", 32'(busy), 32'(ph == P_LOAD || ph == P_CHK || ph == P_RUN));
      chk("cyc done", 32'(done), 32'(ph == P_DONE));
      chk("cyc err", 32'(err), 32'(ph == P_ERR));
      chk("cyc core_rst", 32'(core_rst), 32'(!(ph == P_RUN || ph == P_DONE)));
      chk("cyc err_code", 32'(err_code), 32'(m_code));
      chk("cyc cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
      chk("cyc mem_we", 32'(mem_we), 32'(ph == P_LOAD && in_valid));
      if (ph == P_LOAD && in_valid && m_nacc < 16) begin
        chk("cyc mem_addr", 32'(mem_addr), 32'(m_nacc));
        chk("cyc mem_wdata", mem_wdata, prog[m_nacc]);
      end
      if (mem_we) begin
        mem_img[mem_addr] = mem_wdata;
        wcount++;
      end
    end
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic look();
    @(negedge clk1);
  endtask

  task automatic do_reset();
    rst = 1'b1; load_req = 1'b0; in_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic start_load(input int n);
    load_req = 1'b1;
    load_len = 11'(n);
    tick();
    load_req = 1'b0;
  endtask

  task automatic send_raw(input logic [31:0] d, input bit gap);
    if (gap) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_prog(input int n, input bit gaps);
    logic [31:0] x;
    x = '0;
    start_load(n);
    for (int i = 0; i < n; i++) begin
      send_raw(prog[i], gaps);
      x = x ^ prog[i];
    end
    if (CSUM) send_raw(x, gaps);
  endtask

  task automatic set_fact();
    prog[0] = 32'h280a00c8; prog[1] = 32'h28020001; prog[2]  = 32'h0e94a000;
    prog[3] = 32'h21430000; prog[4] = 32'h0e94a000; prog[5]  = 32'h14431000;
    prog[6] = 32'h2c630001; prog[7] = 32'h0e94a000; prog[8]  = 32'h3460fffc;
    prog[9] = 32'h2542fffe; prog[10] = 32'hfc000000;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++) mem_img[i] = 32'hdeadbeef;
    wcount = 0;
  endtask

  task automatic check_img(input string nm, input int n);
    chk({nm, " write count"}, 32'(wcount), 32'(n));
    for (int i = 0; i < n; i++) chk({nm, " mem word"}, mem_img[i], prog[i]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) prog[i] = '0;
    do_reset();
    look();
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst core_rst", 32'(core_rst), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst err_code", 32'(err_code), 32'd0);
    chk("rst cycle_cnt", 32'(cycle_cnt), 32'd0);

    // Factorial load, no gaps; core halts after 40 run cycles.
    set_fact();
    clear_img();
    load_prog(11, 1'b0);
    look();
    chk("fact core_rst released", 32'(core_rst), 32'd0);
    chk("fact busy in run", 32'(busy), 32'd1);
    repeat (40) tick();
    core_halted = 1'b1;
    tick();
    look();
    chk("fact done", 32'(done), 32'd1);
    chk("fact cycle_cnt", 32'(cycle_cnt), 32'd40);
    chk("fact core_rst in done", 32'(core_rst), 32'd0);
    check_img("fact", 11);

    // Backpressure: bubble before every word; load_req while running is ignored.
    core_halted = 1'b0;
    clear_img();
    load_prog(11, 1'b1);
    start_load(0);
    repeat (3) tick();
    core_halted = 1'b1;
    tick();
    look();
    chk("bp done", 32'(done), 32'd1);
    chk("bp err", 32'(err), 32'd0);
    chk("bp cycle_cnt", 32'(cycle_cnt), 32'd4);
    check_img("bp", 11);

    // Bad lengths: 0 and one past the memory size.
    core_halted = 1'b0;
    wcount = 0;
    start_load(0);
    look();
    chk("len0 err", 32'(err), 32'd1);
    chk("len0 err_code", 32'(err_code), 32'd1);
    chk("len0 core_rst", 32'(core_rst), 32'd1);
    chk("len0 done cleared", 32'(done), 32'd0);
    start_load(1025);
    look();
    chk("len1025 err_code", 32'(err_code), 32'd1);
    chk("badlen no writes", 32'(wcount), 32'd0);

    // Mid-load reset, then a fresh 3-word load.
    start_load(11);
    for (int i = 0; i < 5; i++) send_raw(prog[i], 1'b0);
    look();
    chk("midload err cleared", 32'(err), 32'd0);
    chk("midload busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    look();
    chk("midload rst busy", 32'(busy), 32'd0);
    chk("midload rst in_ready", 32'(in_ready), 32'd0);
    prog[0] = 32'h11111111; prog[1] = 32'h22222222; prog[2] = 32'h44444444;
    clear_img();
    load_prog(3, 1'b0);
    look();
    check_img("short", 3);
    chk("short core_rst", 32'(core_rst), 32'd0);
    core_halted = 1'b1;
    tick();
    core_halted = 1'b0;

    // Timeout on the TIMEOUT=16 instance.
    do_reset();
    prog[0] = 32'd1; prog[1] = 32'd2;
    load_prog(2, 1'b0);
    repeat (15) tick();
    look();
    chk("tmo pre err", 32'(err_t), 32'd0);
    chk("tmo pre cnt", 32'(cycle_cnt_t), 32'd15);
    chk("tmo pre core_rst", 32'(core_rst_t), 32'd0);
    tick();
    look();
    chk("tmo err", 32'(err_t), 32'd1);
    chk("tmo err_code", 32'(err_code_t), 32'd3);
    chk("tmo cnt", 32'(cycle_cnt_t), 32'd16);
    chk("tmo core_rst", 32'(core_rst_t), 32'd1);
    chk("tmo busy", 32'(busy_t), 32'd0);
    chk("tmo in_ready", 32'(in_ready_t), 32'd0);

    // Halt on the would-be timeout cycle: done wins.
    do_reset();
    load_prog(2, 1'b0);
    repeat (15) tick();
    halted_t = 1'b1;
    tick();
    look();
    chk("tie done", 32'(done_t), 32'd1);
    chk("tie err", 32'(err_t), 32'd0);
    chk("tie err_code", 32'(err_code_t), 32'd0);
    chk("tie cnt", 32'(cycle_cnt_t), 32'd15);
    halted_t = 1'b0;

    do_reset();
`ifdef CHECKSUM_EN
    start_load(2);
    send_raw(prog[0], 1'b0);
    send_raw(prog[1], 1'b0);
    send_raw(32'd3, 1'b0);
    look();
    chk("csum good busy", 32'(busy), 32'd1);
    chk("csum good core_rst", 32'(core_rst), 32'd0);
    core_halted = 1'b1;
    tick();
    core_halted = 1'b0;
    start_load(2);
    send_raw(prog[0], 1'b0);
    send_raw(prog[1], 1'b0);
    send_raw(32'd4, 1'b0);
    look();
    chk("csum bad err", 32'(err), 32'd1);
    chk("csum bad err_code", 32'(err_code), 32'd2);
    chk("csum bad core_rst", 32'(core_rst), 32'd1);
`else
    load_prog(2, 1'b0);
    look();
    chk("nocsum run core_rst", 32'(core_rst), 32'd0);
    chk("nocsum run in_ready", 32'(in_ready), 32'd0);
    chk("nocsum run busy", 32'(busy), 32'd1);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
